// File: rtl/fifo_button_ctrl.sv
// Debounces write/read keys into single-cycle FIFO strobes, serialised by an IDLE/WRITE/READ/GAP sequencer.
// Tracks occupancy, holds the last word read for the LEDs, and raises sticky overflow/underflow flags.
module fifo_button_ctrl #(
  parameter int DATA_BITS       = 8,
  parameter int ADDR_BITS       = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_wr_n,
  input  logic                 btn_rd_n,
  input  logic [DATA_BITS-1:0] sw_data,
  input  logic                 fifo_full,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data_out,
  output logic                 fifo_wr_en,
  output logic                 fifo_rd_en,
  output logic [DATA_BITS-1:0] fifo_data_in,
  output logic [DATA_BITS-1:0] led_data,
  output logic [ADDR_BITS:0]   count,
  output logic                 busy,
  output logic                 err_ovf,
  output logic                 err_udf
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]      CNT_ONE = 1;
  localparam logic [CW-1:0]      CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_BITS:0] OCC_ONE = 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, GAP} state_t;

  logic [1:0] raw_n;
  logic [1:0] press;
  assign raw_n = {btn_rd_n, btn_wr_n};

  // Index 0 is the write key, index 1 the read key.
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;

    always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      if (sync_q[1] != lvl_q) begin
        if (cnt_q == CNT_MAX) begin
          lvl_d = sync_q[1];
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= 2'b11;
        cnt_q  <= '0;
        lvl_q  <= 1'b1;
      end else begin
        sync_q <= {sync_q[0], raw_n[b]};
        cnt_q  <= cnt_d;
        lvl_q  <= lvl_d;
      end
    end

    assign press[b] = lvl_q & ~lvl_d;
  end

  state_t                 state_q;
  logic                   wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
  logic                   take_wr, take_rd;
  logic [DATA_BITS-1:0]   data_in_q, led_q;
  logic [ADDR_BITS:0]     count_q;
  logic                   ovf_q, udf_q;

  assign take_wr = (state_q == IDLE) && wr_pend_q;
  assign take_rd = (state_q == IDLE) && !wr_pend_q && rd_pend_q;

  // A fresh press wins over the clear, so a press in the serving cycle is not lost.
  always_comb begin
    wr_pend_d = (wr_pend_q & ~take_wr) | press[0];
    rd_pend_d = (rd_pend_q & ~take_rd) | press[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      wr_pend_q <= wr_pend_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      data_in_q <= '0;
      led_q     <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_pend_q) begin
            state_q   <= WRITE;
            data_in_q <= sw_data;
          end else if (rd_pend_q) begin
            state_q <= READ;
          end
        end
        WRITE: begin
          if (!fifo_full) count_q <= count_q + OCC_ONE;
          else            ovf_q   <= 1'b1;
          state_q <= GAP;
        end
        READ: begin
          if (!fifo_empty) begin
            led_q   <= fifo_data_out;
            count_q <= count_q - OCC_ONE;
          end else begin
            udf_q <= 1'b1;
          end
          state_q <= GAP;
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_wr_en   = (state_q == WRITE) && !fifo_full;
  assign fifo_rd_en   = (state_q == READ) && !fifo_empty;
  assign fifo_data_in = data_in_q;
  assign led_data     = led_q;
  assign count        = count_q;
  assign busy         = (state_q != IDLE);
  assign err_ovf      = ovf_q;
  assign err_udf      = udf_q;

endmodule
